// File: rtl/parallel_to_serial_if.sv
// Parallel-in / serial-out link bundle: word handshake from the source, serial stream and status from the serializer.
interface parallel_to_serial_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_out;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, serial_out, frame_start, frame_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, serial_out, frame_start, frame_last, busy
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Transmit end of the framing-free serial link: one word shifted out per WIDTH clocks,
// with a one-word holding buffer so back-to-back frames leave no idle gap.
module parallel_to_serial #(
  parameter int WIDTH      = 10,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parallel_to_serial_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    SHIFT    = 1'b1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             serial_q, serial_d;
  logic             start_q, start_d;
  logic             last_q, last_d;

  logic             xfer;
  logic             at_last;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // serial_q already carries the current bit, so shift_q only holds the bits still to go.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign xfer    = bus.in_valid && !hold_valid_q;
  assign at_last = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    serial_d     = serial_q;
    load         = 1'b0;
    load_word    = '0;

    if (state_q == IDLE) begin
      if (xfer) begin
        load      = 1'b1;
        load_word = bus.in_data;
      end
    end else if (!at_last) begin
      serial_d  = first_bit(shift_q);
      shift_d   = drop_bit(shift_q);
      bit_cnt_d = bit_cnt_q + CW'(1);
      if (xfer) begin
        hold_d       = bus.in_data;
        hold_valid_d = 1'b1;
      end
    end else if (hold_valid_q) begin
      load         = 1'b1;
      load_word    = hold_q;
      hold_valid_d = 1'b0;
    end else if (xfer) begin
      // Bypass: a word arriving in the last-bit cycle goes straight into the shifter.
      load      = 1'b1;
      load_word = bus.in_data;
    end else begin
      state_d   = IDLE;
      serial_d  = IDLE_LEVEL;
      shift_d   = '0;
      bit_cnt_d = '0;
    end

    if (load) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      serial_d  = first_bit(load_word);
      shift_d   = drop_bit(load_word);
    end

    start_d = load;
    last_d  = (state_d == SHIFT) && (bit_cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      serial_q     <= IDLE_LEVEL;
      start_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      serial_q     <= serial_d;
      start_q      <= start_d;
      last_q       <= last_d;
    end
  end

  assign bus.in_ready    = !hold_valid_q;
  assign bus.serial_out  = serial_q;
  assign bus.frame_start = start_q;
  assign bus.frame_last  = last_q;
  assign bus.busy        = (state_q == SHIFT) || hold_valid_q;
endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: default build plus an LSB-first, idle-high build,
// with a deserializer scoreboard on the default build's serial stream.
module tb_parallel_to_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  parallel_to_serial_if #(.WIDTH(10)) bus0 ();
  parallel_to_serial_if #(.WIDTH(10)) bus1 ();

  parallel_to_serial #(.WIDTH(10)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  parallel_to_serial #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rx_cnt = 0;
  int         rx_words = 0;
  logic [9:0] rx_word = '0;
  logic [9:0] exp_q[$];
  int         start_cyc[$];
  bit         last_acc = 1'b0;
  bit         saw_not_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Deserializer model: rebuilds words MSB-first starting at each frame_start.
  task automatic monitor();
    if (bus0.frame_start) begin
      chk("no_partial_frame", rx_cnt, 0);
      rx_cnt  = 0;
      rx_word = '0;
      start_cyc.push_back(cyc);
    end
    if (bus0.frame_start || rx_cnt > 0) begin
      chk("busy_in_frame", bus0.busy, 1);
      rx_word = {rx_word[8:0], bus0.serial_out};
      rx_cnt++;
      if (rx_cnt == 10) begin
        chk("frame_last_end", bus0.frame_last, 1);
        chk("have_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("rx_word", rx_word, exp_q.pop_front());
        rx_words++;
        rx_cnt = 0;
      end else begin
        chk("frame_last_mid", bus0.frame_last, 0);
      end
    end else begin
      chk("idle_level", bus0.serial_out, 0);
    end
  endtask

  task automatic tick();
    last_acc = bus0.in_valid && bus0.in_ready && rst_n;
    if (last_acc) exp_q.push_back(bus0.in_data);
    if (!bus0.in_ready) saw_not_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic send(input logic [9:0] w);
    int n;
    bus0.in_valid = 1'b1;
    bus0.in_data  = w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 40);
    chk("send_accepted", last_acc, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_q.delete();
    rx_cnt = 0;
    rst_n  = 1'b1;
  endtask

  initial begin
    logic [9:0] pat;
    int n;
    int acc_n;
    int rx_base;

    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    @(negedge clk);
    do_reset();

    chk("rst_serial", bus0.serial_out, 0);
    chk("rst_start", bus0.frame_start, 0);
    chk("rst_last", bus0.frame_last, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_ready", bus0.in_ready, 1);
    chk("rst_serial_idle_hi", bus1.serial_out, 1);

    // LSB-first, idle-high build: 0x001 -> 1 then nine 0s, then idle 1.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 10'h001;
    tick();
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("lsb_bit", bus1.serial_out, (i == 0) ? 1 : 0);
      chk("lsb_start", bus1.frame_start, (i == 0) ? 1 : 0);
      chk("lsb_last", bus1.frame_last, (i == 9) ? 1 : 0);
      if (i < 9) tick();
    end
    tick();
    chk("lsb_idle_after", bus1.serial_out, 1);
    chk("lsb_busy_after", bus1.busy, 0);

    // Single word 0x2D5 -> 1,0,1,1,0,1,0,1,0,1.
    pat = 10'h2D5;
    send(10'h2D5);
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("single_bit", bus0.serial_out, pat[9-i]);
      chk("single_start", bus0.frame_start, (i == 0) ? 1 : 0);
      chk("single_last", bus0.frame_last, (i == 9) ? 1 : 0);
      if (i < 9) tick();
    end
    tick();
    chk("single_idle_after", bus0.serial_out, 0);
    chk("single_busy_after", bus0.busy, 0);

    // Back-to-back words with in_valid held high: starts exactly 10 cycles apart.
    start_cyc.delete();
    saw_not_ready = 1'b0;
    send(10'h3FF);
    send(10'h000);
    send(10'h155);
    bus0.in_valid = 1'b0;
    repeat (25) tick();
    chk("b2b_frames", start_cyc.size(), 3);
    if (start_cyc.size() == 3) begin
      chk("b2b_gap1", start_cyc[1] - start_cyc[0], 10);
      chk("b2b_gap2", start_cyc[2] - start_cyc[1], 10);
    end
    chk("b2b_saw_not_ready", saw_not_ready, 1);

    // Bypass: word offered in the frame_last cycle with hold empty.
    send(10'h0F0);
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.frame_last && n < 20) begin
      tick();
      n++;
    end
    chk("bypass_reach_last", bus0.frame_last, 1);
    chk("bypass_ready_at_last", bus0.in_ready, 1);
    bus0.in_valid = 1'b1;
    bus0.in_data  = 10'h30F;
    tick();
    bus0.in_valid = 1'b0;
    chk("bypass_accepted", last_acc, 1);
    chk("bypass_start", bus0.frame_start, 1);
    chk("bypass_hold_empty", bus0.in_ready, 1);
    repeat (12) tick();

    // Reset at bit 4 with a word held abandons both.
    send(10'h2D5);
    send(10'h0AA);
    bus0.in_valid = 1'b0;
    chk("midrst_hold_full", bus0.in_ready, 0);
    repeat (3) tick();
    do_reset();
    chk("midrst_serial", bus0.serial_out, 0);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_ready", bus0.in_ready, 1);
    chk("midrst_start", bus0.frame_start, 0);
    repeat (3) tick();
    send(10'h155);
    bus0.in_valid = 1'b0;
    chk("midrst_fresh_start", bus0.frame_start, 1);
    repeat (12) tick();

    // Random in_valid stalls over 1000 words, checked by the deserializer scoreboard.
    acc_n   = 0;
    n       = 0;
    rx_base = rx_words;
    while (acc_n < 1000 && n < 20000) begin
      bus0.in_valid = ($urandom_range(0, 2) != 0);
      bus0.in_data  = 10'($urandom);
      tick();
      if (last_acc) acc_n++;
      n++;
    end
    bus0.in_valid = 1'b0;
    chk("rand_accepted", acc_n, 1000);
    n = 0;
    while ((exp_q.size() > 0 || rx_cnt > 0) && n < 100) begin
      tick();
      n++;
    end
    chk("rand_received", rx_words - rx_base, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);
    tick();
    chk("rand_busy_end", bus0.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
Serializer, the transmit end of the team's 10-bit MSB-first serial link. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding buffer gives gap-free back-to-back frames. The link has no framing bits, so the receiver's bit alignment depends on serial_out starting each frame exactly at a frame boundary and never inserting a partial frame.

Parameters:
WIDTH, 10, word/frame length in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
IDLE_LEVEL, 0, serial_out level while no frame is in flight

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  WIDTH  parallel word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
serial_out  output  1  serial bit stream, registered
frame_start  output  1  high during the cycle carrying a frame's first bit
frame_last  output  1  high during the cycle carrying a frame's last bit
busy  output  1  frame in flight or word held

Behaviour:
- Reset: clk and rst_n as above; rst_n sampled only on the clk rising edge, active-low. Resulting values: serial_out=IDLE_LEVEL, frame_start=0, frame_last=0, busy=0, shifter/bit_cnt/hold cleared, state=IDLE. Reset mid-frame abandons the frame and any held word; no further bits of it are sent.
- Handshake: transfer occurs on an edge where in_valid && in_ready. in_ready = !hold_valid (combinational from a register). in_data is ignored when no transfer occurs. in_valid may rise or fall freely.
- States: IDLE (no frame), SHIFT (frame in flight). bit_cnt is 0..WIDTH-1, counting the bits of the current frame.
- IDLE, transfer at edge k: word loads directly into the shifter; state becomes SHIFT and bit_cnt becomes 0. After edge k, serial_out = first bit and frame_start=1. Latency: 1 edge.
- SHIFT, bit_cnt < WIDTH-1: each edge advances one bit and increments bit_cnt. A transfer goes into hold (hold_valid=1).
- SHIFT, bit_cnt == WIDTH-1 (frame_last=1):
  - Next edge with hold_valid: load hold into shifter, clear hold, bit_cnt=0, stay in SHIFT. No idle gap.
  - Else, with a transfer on that edge (hold empty, so in_ready=1): bypass, loading in_data directly into shifter. No gap.
  - Else: go to IDLE, serial_out=IDLE_LEVEL.
- Bit order: MSB_FIRST=1 sends in_data[WIDTH-1] down to [0]; MSB_FIRST=0 sends [0] up to [WIDTH-1].
- Full: hold_valid=1 forces in_ready=0 until the shifter reloads from hold. Only one word is ever buffered; no word is dropped or duplicated.
- busy = (state==SHIFT) || hold_valid.
- frame_start and frame_last are registered alongside serial_out and are aligned to it.

Test Plan:
- Reset then a single word 10'h2D5 (MSB_FIRST=1) at edge k -> serial_out 1,0,1,1,0,1,0,1,0,1 on cycles k+1..k+10. frame_start is high only at k+1 and frame_last only at k+10. serial_out=0 and busy=0 from k+11.
- in_valid held high with 10'h3FF, 10'h000, 10'h155 -> 30 consecutive bits with no idle cycle. in_ready is low while hold is full. Looped into a 10-bit MSB-first deserializer reset in the same cycle, the deserializer's valid pulses carry 3FF, 000, 155 in order.
- Word offered exactly in the frame_last cycle with hold empty -> bypass load. The next frame_start follows frame_last immediately; hold_valid stays 0.
- MSB_FIRST=0, word 10'h001 -> first serial bit 1, then nine 0s. IDLE_LEVEL=1 build -> serial_out=1 when idle and after reset.
- rst_n low at bit 4 of 10'h2D5 with a word held -> after that edge serial_out=IDLE_LEVEL, busy=0, in_ready=1. The next accepted word starts a fresh full frame with frame_start.
- Random in_valid stalls over 1000 words -> scoreboard shows every accepted word is transmitted exactly once, in order, with no partial frames.
